// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU serial front end: frame layout, error
// flag positions, legal operations and CRC parameters.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    // start + type + payload + stop
    localparam int FRAME_LEN = 11;
    localparam int DATA_BITS = FRAME_LEN - 3;

    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CMD  = 1'b1;

    localparam logic [3:0] DATA_BYTES_EXP = 4'd8;
    localparam logic [3:0] DATA_CNT_MAX   = 4'd9;

    localparam int         CRC_DATA_W = 68;
    localparam logic [3:0] CRC_SEED   = 4'h0;
    localparam logic [3:0] CRC_POLY   = 4'b0011;

    function automatic logic op_is_valid(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: op_is_valid = 1'b1;
            default:                       op_is_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// Combinational CRC4 (x^4+x+1) over a 68-bit vector, MSB first, with seed.
// Kept standalone so the result path can reuse it.
module mtm_alu_crc4
    import mtm_alu_pkg::*;
(
    input  logic [CRC_DATA_W-1:0] data_i,
    input  logic [3:0]            seed_i,
    output logic [3:0]            crc_o
);

    logic [3:0] crc;
    logic       fb;

    always_comb begin
        crc = seed_i;
        fb  = 1'b0;
        for (int i = CRC_DATA_W - 1; i >= 0; i--) begin
            fb  = crc[3] ^ data_i[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'h0);
        end
        crc_o = crc;
    end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial frame receiver: assembles DATA bytes into {B,A}, validates the CMD
// byte (count, CRC, opcode) and presents one result pulse per packet.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_A,
    output logic [31:0] out_B,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err,
    output logic        frame_err
);

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic        type_q;
    logic [7:0]  byte_q;
    logic [3:0]  dcnt_q;
    logic [63:0] ba_q;

    logic        out_valid_q, frame_err_q;
    logic [31:0] out_a_q, out_b_q;
    logic [2:0]  out_op_q, out_err_q;

    logic        data_accept, cmd_accept, stop_bad;
    logic [3:0]  crc_calc;
    logic [2:0]  err_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (!sin) state_d = ST_TYPE;
            ST_TYPE: state_d = ST_DATA;
            ST_DATA: if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        data_accept = 1'b0;
        cmd_accept  = 1'b0;
        stop_bad    = 1'b0;
        if (state_q == ST_STOP) begin
            stop_bad    = !sin;
            data_accept = sin && (type_q == TYPE_DATA);
            cmd_accept  = sin && (type_q == TYPE_CMD);
        end
    end

    // Frame payload capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            type_q    <= 1'b0;
            byte_q    <= '0;
        end else if (state_q == ST_TYPE) begin
            type_q    <= sin;
            bit_cnt_q <= '0;
        end else if (state_q == ST_DATA) begin
            byte_q    <= {byte_q[6:0], sin};
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    // Packet assembly; a stop-bit violation drops everything gathered so far
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            ba_q   <= '0;
        end else if (cmd_accept || stop_bad) begin
            dcnt_q <= '0;
            ba_q   <= '0;
        end else if (data_accept) begin
            ba_q   <= {ba_q[55:0], byte_q};
            dcnt_q <= (dcnt_q == DATA_CNT_MAX) ? DATA_CNT_MAX : dcnt_q + 4'd1;
        end
    end

    mtm_alu_crc4 u_crc4 (
        .data_i ( {ba_q, 1'b1, byte_q[6:4]}),
        .seed_i (CRC_SEED),
        .crc_o  (crc_calc)
    );

    // A wrong byte count makes the CRC/op fields meaningless, so it masks them
    always_comb begin
        err_d = '0;
        if (dcnt_q != DATA_BYTES_EXP) begin
            err_d[ERR_DATA_BIT] = 1'b1;
        end else begin
            err_d[ERR_CRC_BIT] = (crc_calc != byte_q[3:0]);
            err_d[ERR_OP_BIT]  = !op_is_valid(byte_q[6:4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_op_q    <= '0;
            out_err_q   <= '0;
        end else begin
            out_valid_q <= cmd_accept;
            frame_err_q <= stop_bad;
            if (cmd_accept) begin
                out_err_q <= err_d;
                out_op_q  <= byte_q[6:4];
                out_a_q   <= (err_d == 3'b000) ? ba_q[31:0]  : 32'h0;
                out_b_q   <= (err_d == 3'b000) ? ba_q[63:32] : 32'h0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign out_A     = out_a_q;
    assign out_B     = out_b_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench: serial packets driven frame by frame, results captured
// by a monitor and compared with a reference model built from the frame rules.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sin = 1'b1;
    logic        out_valid, frame_err;
    logic [31:0] out_A, out_B;
    logic [2:0]  out_op, out_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
    } res_t;

    res_t got_q[$];
    int   ferr_cnt = 0;

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_valid (out_valid),
        .out_A     (out_A),
        .out_B     (out_B),
        .out_op    (out_op),
        .out_err   (out_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Every cycle out_valid is high yields one entry, so a stretched pulse shows up as extras
    always @(negedge clk) begin
        if (out_valid) got_q.push_back('{out_A, out_B, out_op, out_err});
        if (frame_err) ferr_cnt++;
    end

    // Remainder of m(x)*x^4 divided by x^4+x+1
    function automatic logic [3:0] crc_ref(input logic [67:0] m);
        logic [71:0] r;
        r = {m, 4'h0};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] err_ref(input int n, input logic [63:0] ba,
                                           input logic [2:0] op, input logic [3:0] crc);
        logic [2:0] e;
        if (n != 8) return 3'b100;
        e = 3'b000;
        e[1] = (crc != crc_ref({ba, 1'b1, op}));
        e[0] = !(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101);
        return e;
    endfunction

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        logic [10:0] f;
        f = {1'b0, typ, d, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = f[i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sin = 1'b1;
        end
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [3:0] crc);
        for (int i = 0; i < 4; i++) send_frame(1'b0, b[31 - 8*i -: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_frame(1'b0, a[31 - 8*i -: 8], 1'b1);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_A !== 32'h0) begin errors++; $display("FAIL reset_A: got %h want 0", out_A); end
        checks++; if (out_B !== 32'h0) begin errors++; $display("FAIL reset_B: got %h want 0", out_B); end
        checks++; if (out_op !== 3'b0) begin errors++; $display("FAIL reset_op: got %b want 000", out_op); end
        checks++; if (out_err !== 3'b0) begin errors++; $display("FAIL reset_err: got %b want 000", out_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_spec_vector;
        got_q.delete(); ferr_cnt = 0;
        send_packet(32'h1, 32'h2, 3'b100, crc_ref({32'h2, 32'h1, 1'b1, 3'b100}));
        idle(3);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL vec_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0].a !== 32'h1) begin errors++; $display("FAIL vec_A: got %h want 1", got_q[0].a); end
            checks++; if (got_q[0].b !== 32'h2) begin errors++; $display("FAIL vec_B: got %h want 2", got_q[0].b); end
            checks++; if (got_q[0].op !== 3'b100) begin errors++; $display("FAIL vec_op: got %b want 100", got_q[0].op); end
            checks++; if (got_q[0].err !== 3'b000) begin errors++; $display("FAIL vec_err: got %b want 000", got_q[0].err); end
        end
        checks++; if (out_A !== 32'h1 || out_B !== 32'h2) begin errors++; $display("FAIL vec_hold: got %h/%h want 1/2", out_A, out_B); end
    endtask

    task automatic test_short_packet;
        got_q.delete(); ferr_cnt = 0;
        for (int i = 0; i < 3; i++) send_frame(1'b0, 8'(8'h10 + i), 1'b1);
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'(8'h20 + i), 1'b1);
        send_frame(1'b1, {1'b0, 3'b100, 4'h5}, 1'b1);
        idle(3);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL short_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0].err !== 3'b100) begin errors++; $display("FAIL short_err: got %b want 100", got_q[0].err); end
            checks++; if (got_q[0].a !== 32'h0 || got_q[0].b !== 32'h0) begin errors++; $display("FAIL short_zero: got %h/%h want 0/0", got_q[0].a, got_q[0].b); end
        end
    endtask

    task automatic test_crc_error;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        got_q.delete(); ferr_cnt = 0;
        send_packet(a, b, 3'b001, crc_ref({b, a, 1'b1, 3'b001}) ^ 4'h1);
        idle(3);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL crc_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0].err !== 3'b010) begin errors++; $display("FAIL crc_err: got %b want 010", got_q[0].err); end
            checks++; if (got_q[0].a !== 32'h0 || got_q[0].b !== 32'h0) begin errors++; $display("FAIL crc_zero: got %h/%h want 0/0", got_q[0].a, got_q[0].b); end
        end
    endtask

    task automatic test_bad_op;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        got_q.delete(); ferr_cnt = 0;
        send_packet(a, b, 3'b010, crc_ref({b, a, 1'b1, 3'b010}));
        send_packet(a, b, 3'b010, crc_ref({b, a, 1'b1, 3'b010}) ^ 4'h6);
        idle(3);
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL badop_count: got %0d want 2", got_q.size()); end
        if (got_q.size() > 1) begin
            checks++; if (got_q[0].err !== 3'b001) begin errors++; $display("FAIL badop_err: got %b want 001", got_q[0].err); end
            checks++; if (got_q[1].err !== 3'b011) begin errors++; $display("FAIL badop_crc_err: got %b want 011", got_q[1].err); end
        end
    endtask

    task automatic test_frame_error;
        got_q.delete(); ferr_cnt = 0;
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'(8'hA0 + i), 1'b1);
        send_frame(1'b0, 8'h55, 1'b0);
        idle(2);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles want 1", ferr_cnt); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d want 0", got_q.size()); end
        send_packet(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, crc_ref({64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b000}));
        idle(3);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_recover_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].err !== 3'b000 || got_q[0].a !== 32'hFFFF_FFFF || got_q[0].b !== 32'hFFFF_FFFF || got_q[0].op !== 3'b000) begin
                errors++;
                $display("FAIL ferr_recover: got A=%h B=%h op=%b err=%b want A=B=ffffffff op=000 err=000",
                         got_q[0].a, got_q[0].b, got_q[0].op, got_q[0].err);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] a, b;
        logic [10:0] f;
        a = $urandom; b = $urandom;
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'h30 + i), 1'b1);
        f = {1'b0, 1'b0, 8'hC3, 1'b1};
        for (int i = 10; i >= 6; i--) begin
            @(negedge clk);
            sin = f[i];
        end
        #2 rst_n = 1'b0; sin = 1'b1;
        #1;
        checks++; if (out_A !== 32'h0 || out_B !== 32'h0) begin errors++; $display("FAIL async_reset: got %h/%h want 0/0", out_A, out_B); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        got_q.delete(); ferr_cnt = 0;
        send_packet(a, b, 3'b101, crc_ref({b, a, 1'b1, 3'b101}));
        idle(3);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rst_mid_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].err !== 3'b000 || got_q[0].a !== a || got_q[0].b !== b || got_q[0].op !== 3'b101) begin
                errors++;
                $display("FAIL rst_mid_result: got A=%h B=%h op=%b err=%b want A=%h B=%h op=101 err=000",
                         got_q[0].a, got_q[0].b, got_q[0].op, got_q[0].err, a, b);
            end
        end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL rst_mid_ferr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_sin_low;
        got_q.delete(); ferr_cnt = 0;
        repeat (44) begin
            @(negedge clk);
            sin = 1'b0;
        end
        idle(3);
        checks++; if (ferr_cnt !== 4) begin errors++; $display("FAIL low_ferr: got %0d want 4", ferr_cnt); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL low_no_valid: got %0d want 0", got_q.size()); end
        send_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, crc_ref({32'h9ABC_DEF0, 32'h1234_5678, 1'b1, 3'b001}));
        idle(3);
        checks++;
        if (got_q.size() !== 1 || got_q[got_q.size() == 0 ? 0 : got_q.size() - 1].a !== 32'h1234_5678) begin
            errors++;
            $display("FAIL low_recover: got %0d results want 1 with A=12345678", got_q.size());
        end
    endtask

    task automatic test_back_to_back;
        res_t exp_q[$];
        logic [31:0] a, b;
        logic [2:0]  op, e;
        logic [3:0]  crc, good;
        logic [63:0] ba;
        int n;
        got_q.delete(); ferr_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            a = $urandom; b = $urandom;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: n = 7;
                1: n = 9;
                2: n = 10;
                default: n = 8;
            endcase
            good = crc_ref({b, a, 1'b1, op});
            crc = ($urandom_range(0, 2) == 0) ? good ^ 4'($urandom_range(1, 15)) : good;
            ba = {b, a};
            for (int i = 0; i < n; i++)
                send_frame(1'b0, (n == 8) ? ba[63 - 8*i -: 8] : 8'($urandom), 1'b1);
            send_frame(1'b1, {1'b0, op, crc}, 1'b1);
            e = err_ref(n, ba, op, crc);
            exp_q.push_back('{(e == 3'b000) ? a : 32'h0, (e == 3'b000) ? b : 32'h0, op, e});
            idle($urandom_range(0, 2));
        end
        idle(3);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].a !== exp_q[i].a || got_q[i].b !== exp_q[i].b ||
                got_q[i].op !== exp_q[i].op || got_q[i].err !== exp_q[i].err) begin
                errors++;
                $display("FAIL b2b_pkt%0d: got A=%h B=%h op=%b err=%b want A=%h B=%h op=%b err=%b", i,
                         got_q[i].a, got_q[i].b, got_q[i].op, got_q[i].err,
                         exp_q[i].a, exp_q[i].b, exp_q[i].op, exp_q[i].err);
            end
        end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
    endtask

    initial begin
        test_reset;
        test_spec_vector;
        test_short_packet;
        test_crc_error;
        test_bad_op;
        test_frame_error;
        test_reset_mid_frame;
        test_sin_low;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
